// File: rtl/uart_tx.sv
// uart_tx: pops words from an upstream FIFO and shifts them out LSB first as start/data/stop frames.
// Defining UART_TX_PARITY_EN adds an even-parity bit between the data and stop bits.
module uart_tx #(
    parameter int N         = 8,
    parameter int DVSR      = 16,
    parameter int STOP_BITS = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tx_en,
    input  logic         fifo_empty,
    input  logic [N-1:0] rd_data,
    output logic         rd,
    output logic         tx,
    output logic         tx_busy,
    output logic         frame_done
);
    localparam int TICK_W  = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int IDX_MAX = (N > STOP_BITS) ? N : STOP_BITS;
    localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DVSR - 1);
    localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [N-1:0]      shift_q, shift_d;
    logic              tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic tick_last;

    assign tick_last  = (tick_q == TICK_LAST);
    assign rd         = (state_q == IDLE) & tx_en & ~fifo_empty & ~reset;
    assign tx         = tx_q;
    assign tx_busy    = (state_q != IDLE);
    assign frame_done = (state_q == STOP) & tick_last & (idx_q == STOP_LAST) & ~reset;

    always_comb begin
        // NOTE: every next-state value gets its hold default first, so no path through the case infers a latch.
        state_d  = state_q;
        tick_d   = tick_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (rd) begin
                    shift_d  = rd_data;
                    tick_d   = '0;
                    idx_d    = '0;
                    tx_d     = 1'b0;
                    state_d  = START;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^rd_data;
`endif
                end
            end
            START: begin
                tick_d = tick_q + TICK_W'(1);
                if (tick_last) begin
                    tick_d  = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                tick_d = tick_q + TICK_W'(1);
                if (tick_last) begin
                    tick_d  = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        tx_d  = shift_d[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tick_d = tick_q + TICK_W'(1);
                if (tick_last) begin
                    tick_d  = '0;
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                tick_d = tick_q + TICK_W'(1);
                if (tick_last) begin
                    tick_d = '0;
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments, so every register samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            idx_q    <= '0;
            // NOTE: the shift register is cleared as well, so an abandoned frame leaves no stale word behind.
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx (N=8, DVSR=4, STOP_BITS=1); build with UART_TX_PARITY_EN for the parity variant.
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int N         = 8;
    localparam int DVSR      = 4;
    localparam int STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
    localparam int DONE_AT = 44;
    localparam int PERIOD  = 45;
`else
    localparam int DONE_AT = 40;
    localparam int PERIOD  = 41;
`endif

    typedef struct {
        logic [10:0] bits;   // bit 0 is the first bit on the line
        bit          abort;
    } exp_t;

    exp_t exp_q[$];
    int   rd_log[$];

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         tx_en = 1'b1;
    logic         fifo_empty;
    logic [N-1:0] rd_data;
    logic         rd, tx, tx_busy, frame_done;

    logic [N-1:0] mem [16];
    logic [4:0]   wr_ptr = '0;
    logic [4:0]   rd_ptr = '0;
    int           cyc = 0;
    bit           mon_busy = 0;
    int           checks = 0;
    int           failures = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign rd_data    = mem[rd_ptr[3:0]];

    uart_tx #(.N(N), .DVSR(DVSR), .STOP_BITS(STOP_BITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .rd_data    (rd_data),
        .rd         (rd),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd) rd_ptr <= rd_ptr + 5'd1;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] w, input logic [9:0] f10, input logic [10:0] f11, input bit ab);
        exp_t e;
`ifdef UART_TX_PARITY_EN
        e.bits = f11;
`else
        e.bits = {1'b0, f10};
`endif
        e.abort = ab;
        mem[wr_ptr[3:0]] = w;
        wr_ptr = wr_ptr + 5'd1;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) step();
    endtask

    task automatic wait_rd(input int n);
        for (int i = 0; i < 500 && rd_log.size() < n; i++) step();
        if (rd_log.size() < n) check("rd_timeout", rd_log.size(), n);
    endtask

    task automatic drain();
        for (int i = 0; i < 1000; i++) begin
            if (exp_q.size() == 0 && !mon_busy && fifo_empty) break;
            step();
        end
        check("drained", {exp_q.size() == 0, mon_busy, fifo_empty}, 3'b101);
    endtask

    // Monitor: one scoreboard entry per rd strobe, then the serial waveform of that frame.
    initial begin : monitor
        exp_t        e;
        logic [63:0] got, want;
        bit          aborted, pend_idle, rd_seen, done_extra;
        pend_idle = 0;
        forever begin
            @(negedge clk);
            if (pend_idle) begin
                pend_idle = 0;
                check("idle_gap", {tx, tx_busy}, 2'b10);
            end
            if (reset) begin
                check("rd_in_reset", rd, 1'b0);
            end else if (rd) begin
                rd_log.push_back(cyc);
                mon_busy = 1;
                check("rd_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    got = '0; aborted = 0; rd_seen = 0; done_extra = 0;
                    for (int k = 1; k <= DONE_AT; k++) begin
                        @(negedge clk);
                        if (reset) begin
                            aborted = 1;
                            break;
                        end
                        got[k-1] = tx;
                        if (rd) rd_seen = 1;
                        if (k == DONE_AT) check("frame_done_last", frame_done, 1'b1);
                        else if (frame_done) done_extra = 1;
                    end
                    check("abort_match", aborted, e.abort);
                    if (aborted) begin
                        @(negedge clk);
                        check("abort_idle", {tx, tx_busy, rd}, 3'b100);
                    end else begin
                        want = '0;
                        for (int i = 0; i < DONE_AT; i++) want[i] = e.bits[i / DVSR];
                        check("frame_bits", got, want);
                        check("frame_done_early", done_extra, 1'b0);
                        check("rd_mid_frame", rd_seen, 1'b0);
                        pend_idle = 1;
                    end
                end
                mon_busy = 0;
            end
        end
    end

    initial begin : stimulus
        int t0, rel, n;
        // Reset held with a word waiting and tx_en high.
        push(8'hA5, 10'b1101001010, 11'b10101001010, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outputs", {rd, tx, tx_busy, frame_done}, 4'b0100);
        end
        step();
        reset = 1'b0;
        rel = cyc;
        wait_rd(1);
        check("first_rd_after_reset", rd_log[0], rel);
        drain();

        // Back-to-back words.
        n = rd_log.size();
        push(8'h00, 10'b1000000000, 11'b10000000000, 0);
        push(8'hFF, 10'b1111111110, 11'b10111111110, 0);
        wait_rd(n + 2);
        check("b2b_rd_spacing", rd_log[n+1] - rd_log[n], PERIOD);
        drain();

        // tx_en dropped in DATA with the FIFO still holding a word.
        n = rd_log.size();
        push(8'h3C, 10'b1001111000, 11'b10001111000, 0);
        push(8'h81, 10'b1100000010, 11'b10100000010, 0);
        wait_rd(n + 1);
        t0 = rd_log[n];
        wait_cyc(t0 + 20);
        tx_en = 1'b0;
        wait_cyc(t0 + PERIOD + 6);
        check("no_rd_while_disabled", rd_log.size(), n + 1);
        tx_en = 1'b1;
        rel = cyc;
        wait_rd(n + 2);
        check("rd_on_reenable", rd_log[n+1], rel);
        drain();

        // Reset pulsed during data bit 3.
        n = rd_log.size();
        push(8'h5A, 10'b1010110100, 11'b10010110100, 1);
        push(8'hC3, 10'b1110000110, 11'b10110000110, 0);
        wait_rd(n + 1);
        t0 = rd_log[n];
        wait_cyc(t0 + 18);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        rel = cyc;
        wait_rd(n + 2);
        check("rd_after_abort_release", rd_log[n+1], rel);
        drain();

        // Odd-weight word: parity bit is 1 in the parity build.
        push(8'h07, 10'b1000001110, 11'b11000001110, 0);
        drain();

        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: simulation did not complete (checks=%0d)", checks);
        $fatal(1);
    end

endmodule
